// File: rtl/data_memory_hs_pkg.sv
// Shared types and helpers for data_memory_hs.
// Parity helper is used only when DATA_MEMORY_HS_PARITY_EN is defined.
package data_memory_hs_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned NBYTES     = DATA_W_DEF / 8;

    // Even parity: the stored bit makes the byte plus parity an even count of ones.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/data_memory_hs_if.sv
// Request/response bus for data_memory_hs; master drives requests, slave is the memory.
interface data_memory_hs_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/data_memory_hs_mem_byte_array.sv
// Word storage with per-byte write enables and a registered read port.
// DATA_MEMORY_HS_PARITY_EN adds one even-parity bit per byte and a read-side parity check.
module mem_byte_array
    import data_memory_hs_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 65536,
    parameter int unsigned IDX_W  = 16
) (
    input  logic                clk,
    input  logic                i_wr_en,
    input  logic                i_rd_en,
    input  logic [IDX_W-1:0]    i_addr,
    input  logic [DATA_W/8-1:0] i_be,
    input  logic [DATA_W-1:0]   i_wdata,
`ifdef DATA_MEMORY_HS_PARITY_EN
    input  logic                i_par_inv,
    output logic                o_par_err,
`endif
    output logic [DATA_W-1:0]   o_rdata
);
    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        if (i_rd_en) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

`ifdef DATA_MEMORY_HS_PARITY_EN
    logic [NB-1:0] r_par [DEPTH];
    logic [NB-1:0] r_rpar;
    logic [NB-1:0] w_calc;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (i_be[b]) begin
                    r_par[i_addr][b] <= byte_parity(i_wdata[8*b +: 8]) ^ i_par_inv;
                end
            end
        end
        if (i_rd_en) begin
            r_rpar <= r_par[i_addr];
        end
    end

    always_comb begin
        w_calc = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            w_calc[b] = byte_parity(r_rdata[8*b +: 8]);
        end
    end

    assign o_par_err = |(w_calc ^ r_rpar);
`endif

endmodule

// File: rtl/data_memory_hs.sv
// Valid/ready data memory: one outstanding request, fixed RD_LAT response latency, range check.
// Optional per-byte parity with a par_inject port when DATA_MEMORY_HS_PARITY_EN is defined.
module data_memory_hs
    import data_memory_hs_pkg::*;
#(
    parameter int unsigned DATA_W = 8 * NBYTES,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 65536,
    parameter int unsigned RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef DATA_MEMORY_HS_PARITY_EN
    input  logic            par_inject,
`endif
    data_memory_hs_if.slave bus
);
    localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("data_memory_hs: RD_LAT must be in 1..4");
    end
    if (DATA_W % 8 != 0 || DATA_W == 0) begin : g_bad_width
        $error("data_memory_hs: DATA_W must be a non-zero multiple of 8");
    end
    if (longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_bad_depth
        $error("data_memory_hs: DEPTH exceeds 2**ADDR_W");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_lat_cnt;
    logic              r_we;
    logic              r_oor;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              w_accept;
    logic              w_in_range;
    logic              w_lat_done;
    logic              w_par_err;
    logic [DATA_W-1:0] w_mem_rdata;

    assign bus.req_ready = (r_state == IDLE);
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

    assign w_accept   = bus.req_valid & bus.req_ready & rst_n;
    assign w_in_range = ({1'b0, bus.req_addr} < DEPTH_V);
    assign w_lat_done = (r_state == BUSY) && (r_lat_cnt == '0);

    // Reads sample the array on the accept edge; no write can land before the response.
    mem_byte_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_accept & bus.req_we & w_in_range),
        .i_rd_en   (w_accept & ~bus.req_we & w_in_range),
        .i_addr    (bus.req_addr[IDX_W-1:0]),
        .i_be      (bus.req_be),
        .i_wdata   (bus.req_wdata),
`ifdef DATA_MEMORY_HS_PARITY_EN
        .i_par_inv (par_inject),
        .o_par_err (w_par_err),
`endif
        .o_rdata   (w_mem_rdata)
    );

`ifndef DATA_MEMORY_HS_PARITY_EN
    assign w_par_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)        w_state_nxt = BUSY;
            BUSY:    if (w_lat_done)      w_state_nxt = RESP;
            RESP:    if (bus.rsp_ready)   w_state_nxt = IDLE;
            default:                      w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lat_cnt   <= '0;
            r_we        <= 1'b0;
            r_oor       <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_lat_cnt <= 2'(RD_LAT - 1);
                r_we      <= bus.req_we;
                r_oor     <= ~w_in_range;
            end else if (r_state == BUSY && r_lat_cnt != '0) begin
                r_lat_cnt <= r_lat_cnt - 2'd1;
            end

            if (w_lat_done) begin
                r_rsp_rdata <= (r_we | r_oor) ? '0 : w_mem_rdata;
                r_rsp_err   <= r_oor | (~r_we & w_par_err);
            end else if (r_state == RESP && bus.rsp_ready) begin
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b0;
            end
        end
    end

endmodule
